// File: rtl/dd_bench_pkg.sv
// Shared types and LFSR helpers for the delay-line pattern checker.
package dd_bench_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/dd_pattern_checker_lfsr16.sv
// 16-bit Galois LFSR with synchronous load (priority) and step enable.
module lfsr16
    import dd_bench_pkg::*;
#(
    parameter logic [15:0] RST_VAL = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    logic [15:0] state_d, state_q;

    always_comb begin
        state_d = state_q;
        if (load)
            state_d = seed;
        else if (en)
            state_d = lfsr_next(state_q);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= RST_VAL;
        else
            state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: rtl/dd_pattern_checker.sv
// Drives a dynamic delay line with an LFSR pattern and checks its output
// against a second LFSR that starts once the expected latency has elapsed.
module dd_pattern_checker
    import dd_bench_pkg::*;
#(
    parameter int          WIDTH       = 16,
    parameter int          SEL_W       = 10,
    parameter int          LAT_OFFSET  = 1,
    parameter int          NUM_SAMPLES = 4096,
    parameter logic [15:0] SEED        = DEFAULT_SEED,
    parameter int          ERRC_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SEL_W-1:0]  sel_cfg,
    input  logic              err_inj,
    output logic [WIDTH-1:0]  id,
    output logic [SEL_W-1:0]  sel,
    input  logic [WIDTH-1:0]  od,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERRC_W-1:0] err_cnt
);

    localparam int             SMP_W       = $clog2(NUM_SAMPLES + 1);
    localparam logic [SEL_W:0] LAT         = (SEL_W+1)'(LAT_OFFSET);
    localparam logic [SMP_W-1:0] SAMPLE_LAST = SMP_W'(NUM_SAMPLES - 1);

    if (SEED == 16'h0000) begin : g_seed_chk
        $error("dd_pattern_checker: SEED must be nonzero");
    end
    if (NUM_SAMPLES < 1) begin : g_smp_chk
        $error("dd_pattern_checker: NUM_SAMPLES must be >= 1");
    end

    state_e            state_d, state_q;
    logic [SEL_W:0]    fill_cnt_d, fill_cnt_q;
    logic [SMP_W-1:0]  sample_cnt_d, sample_cnt_q;
    logic [ERRC_W-1:0] err_cnt_d, err_cnt_q;
    logic [SEL_W-1:0]  sel_d, sel_q;
    logic [WIDTH-1:0]  id_d, id_q;

    logic [15:0]       gen_state, chk_state;
    logic [WIDTH-1:0]  gen_word, chk_word, seed_word;
    logic [SEL_W:0]    fill_load;
    logic              start_ok;
    logic              next_busy;

    // The 16-bit pattern is tiled across the lane width
    for (genvar i = 0; i < WIDTH; i++) begin : g_rep
        assign gen_word[i]  = gen_state[i % 16];
        assign chk_word[i]  = chk_state[i % 16];
        assign seed_word[i] = SEED[i % 16];
    end

    assign fill_load = {1'b0, sel_cfg} + LAT;
    assign start_ok  = start && (state_q == IDLE || state_q == DONE);
    assign next_busy = (state_d == FILL) || (state_d == CHECK);

    // Generator runs one word ahead of id so word k is on id in busy cycle k
    lfsr16 #(.RST_VAL(SEED)) u_gen (
        .clk   (clk),
        .rst   (rst),
        .en    (busy),
        .load  (start_ok),
        .seed  (lfsr_next(SEED)),
        .state (gen_state)
    );

    lfsr16 #(.RST_VAL(SEED)) u_chk (
        .clk   (clk),
        .rst   (rst),
        .en    (state_q == CHECK),
        .load  (start_ok),
        .seed  (SEED),
        .state (chk_state)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            fill_cnt_q   <= '0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            sel_q        <= '0;
            id_q         <= '0;
        end else begin
            state_q      <= state_d;
            fill_cnt_q   <= fill_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            sel_q        <= sel_d;
            id_q         <= id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = (fill_load == '0) ? CHECK : FILL;
            FILL:       if (fill_cnt_q == (SEL_W+1)'(1)) state_d = CHECK;
            CHECK:      if (sample_cnt_q == SAMPLE_LAST) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        fill_cnt_d   = fill_cnt_q;
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        sel_d        = sel_q;
        id_d         = '0;
        if (start_ok) begin
            fill_cnt_d   = fill_load;
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            sel_d        = sel_cfg;
            id_d         = seed_word;
        end else if (busy) begin
            if (state_q == FILL)
                fill_cnt_d = fill_cnt_q - (SEL_W+1)'(1);
            if (state_q == CHECK) begin
                sample_cnt_d = sample_cnt_q + SMP_W'(1);
                if (od != chk_word && err_cnt_q != '1)
                    err_cnt_d = err_cnt_q + ERRC_W'(1);
            end
            if (next_busy)
                id_d = gen_word ^ {{(WIDTH-1){1'b0}}, err_inj};
        end
    end

    always_comb begin
        busy = (state_q == FILL) || (state_q == CHECK);
        done = (state_q == DONE);
        pass = (state_q == DONE) && (err_cnt_q == '0);
    end

    assign id      = id_q;
    assign sel     = sel_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_dd_pattern_checker.sv
// Randomized bench: sel+1-register delay line model plus a word-level
// reference of the expected id stream and error count.
module tb_dd_pattern_checker;

    localparam int          NS   = 64;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst, start, err_inj;
    logic [9:0]  sel_cfg;
    logic [15:0] id, od;
    logic [9:0]  sel;
    logic        busy, done, pass;
    logic [15:0] err_cnt;

    logic [15:0] s_id;
    logic [9:0]  s_sel;
    logic        s_busy, s_done, s_pass;
    logic [3:0]  s_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dd_pattern_checker #(.NUM_SAMPLES(NS)) u_dut (
        .clk(clk), .rst(rst), .start(start), .sel_cfg(sel_cfg), .err_inj(err_inj),
        .id(id), .sel(sel), .od(od), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt)
    );

    // Second copy with a narrow counter and a dead delay line output
    dd_pattern_checker #(.NUM_SAMPLES(NS), .ERRC_W(4)) u_sat (
        .clk(clk), .rst(rst), .start(start), .sel_cfg(sel_cfg), .err_inj(err_inj),
        .id(s_id), .sel(s_sel), .od(16'h0000), .busy(s_busy), .done(s_done),
        .pass(s_pass), .err_cnt(s_err)
    );

    // Delay line model: sel+1 registers between id and od
    logic [15:0] dl [0:1023];
    always @(posedge clk) begin
        dl[0] <= id;
        for (int i = 1; i < 1024; i++) dl[i] <= dl[i-1];
    end
    assign od = dl[sel];

    function automatic logic [15:0] lfsr_step(input logic [15:0] w);
        logic [15:0] r;
        r = w >> 1;
        if (w[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One run; inj_c = busy cycle with err_inj high (-1 none), dup_c = busy
    // cycle with a second start and changed sel_cfg (-1 none)
    task automatic run(input logic [9:0] s, input int inj_c, input int dup_c, input string tag);
        int          d, k, exp_err, id_bad, sel_bad;
        logic [15:0] w, e;
        bit          inj_prev;
        d = int'(s) + 1;
        exp_err = (inj_c >= 0 && inj_c <= NS - 2) ? 1 : 0;
        @(negedge clk);
        start = 1'b1; sel_cfg = s; err_inj = 1'b1;
        @(negedge clk);
        start = 1'b0; err_inj = 1'b0;
        w = SEED; k = 0; id_bad = 0; sel_bad = 0; inj_prev = 1'b0;
        while (busy && k < d + NS + 8) begin
            e = inj_prev ? (w ^ 16'h0001) : w;
            if (id !== e) id_bad++;
            if (sel !== s) sel_bad++;
            inj_prev = (k == inj_c);
            err_inj  = inj_prev;
            start    = (k == dup_c);
            if (k == dup_c) sel_cfg = 10'd7;
            w = lfsr_step(w);
            k++;
            @(negedge clk);
        end
        err_inj = 1'b0; start = 1'b0;
        chk({tag, "_busy_len"}, k, d + NS);
        chk({tag, "_id_stream_bad"}, id_bad, 0);
        chk({tag, "_sel_unstable"}, sel_bad, 0);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_pass"}, pass, (exp_err == 0) ? 1 : 0);
        chk({tag, "_err_cnt"}, err_cnt, exp_err);
        chk({tag, "_sel_done"}, sel, s);
        chk({tag, "_id_idle"}, id, 0);
        chk({tag, "_sat_err"}, s_err, 15);
        chk({tag, "_sat_pass"}, s_pass, 0);
        chk({tag, "_sat_done"}, s_done, 1);
        err_inj = 1'b1;
        @(negedge clk);
        err_inj = 1'b0;
        chk({tag, "_inj_done_id"}, id, 0);
        chk({tag, "_inj_done_err"}, err_cnt, exp_err);
        chk({tag, "_done_hold"}, done, 1);
    endtask

    // Reset mid-CHECK, with a simultaneous start that must lose
    task automatic abort_run(input logic [9:0] s);
        int d;
        d = int'(s) + 1;
        @(negedge clk);
        start = 1'b1; sel_cfg = s;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < d + 10; k++) begin
            err_inj = (k == 2);
            @(negedge clk);
        end
        err_inj = 1'b0;
        chk("abort_mid_busy", busy, 1);
        chk("abort_pre_err", err_cnt, 1);
        rst = 1'b1; start = 1'b1; sel_cfg = 10'd9;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err_cnt, 0);
        chk("abort_id", id, 0);
        chk("abort_sel", sel, 0);
        chk("abort_sat_err", s_err, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; err_inj = 1'b0; sel_cfg = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_id", id, 0);
        chk("rst_sel", sel, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        run(10'd0,    -1, -1, "sel0");
        run(10'd1023, -1, -1, "sel1023");
        run(10'd5,     3, -1, "inj_fill");
        run(10'd5,    -1, 20, "dup_start");
        abort_run(10'd3);
        run(10'd2,    -1, -1, "after_abort");
        for (int r = 0; r < 4; r++) begin
            logic [9:0] s;
            int         c;
            s = 10'($urandom_range(0, 300));
            c = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, int'(s) + NS));
            run(s, c, -1, $sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
